// File: rtl/packet_filler.sv
// Stores one beat-stream packet word by word into packetmem and holds it with pkt_ready until pkt_ack.
// Writes land 1 cycle after each accepted beat. pkt_ready rises 2 cycles after the tlast beat. Optional macro PACKET_FILLER_TKEEP_EN.
module packet_filler #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic [3:0]              s_tkeep,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_en,
    output logic                    pkt_ready,
    output logic [ADDR_WIDTH+2:0]   pkt_len,
    output logic                    pkt_trunc,
    input  logic                    pkt_ack
);
    typedef enum logic [1:0] {S_FILL, S_FLUSH, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0] WIDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     widx_q, widx_d;
    logic [ADDR_WIDTH+2:0]   bytes_q, bytes_d;
    logic                    trunc_q, trunc_d;
    logic                    ready_q, ready_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    beat_acc;
    logic [2:0]              beat_bytes;

    assign s_tready = (state_q == S_FILL) & ~rst;
    assign beat_acc = s_tvalid & s_tready;

`ifdef PACKET_FILLER_TKEEP_EN
    // Only the final beat can be partial; earlier beats are always full words.
    assign beat_bytes = s_tlast ? ({2'b00, s_tkeep[3]} + {2'b00, s_tkeep[2]}
                                 + {2'b00, s_tkeep[1]} + {2'b00, s_tkeep[0]})
                                : 3'd4;
`else
    logic unused_tkeep;
    assign unused_tkeep = ^s_tkeep;
    assign beat_bytes   = 3'd4;
`endif

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        bytes_d   = bytes_q;
        trunc_d   = trunc_q;
        ready_d   = ready_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_FILL: begin
                if (beat_acc) begin
                    // widx MSB set means the buffer is full: drop the beat.
                    if (!widx_q[ADDR_WIDTH]) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = widx_q[ADDR_WIDTH-1:0];
                        wr_data_d = s_tdata;
                        widx_d    = widx_q + WIDX_ONE;
                        bytes_d   = bytes_q + {{ADDR_WIDTH{1'b0}}, beat_bytes};
                    end else begin
                        trunc_d = 1'b1;
                    end
                    if (s_tlast) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
                ready_d = 1'b1;
            end
            S_DONE: begin
                if (pkt_ack) begin
                    state_d = S_FILL;
                    ready_d = 1'b0;
                    widx_d  = '0;
                    bytes_d = '0;
                    trunc_d = 1'b0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FILL;
            widx_q    <= '0;
            bytes_q   <= '0;
            trunc_q   <= 1'b0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            bytes_q   <= bytes_d;
            trunc_q   <= trunc_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign pkt_ready = ready_q;
    assign pkt_len   = bytes_q;
    assign pkt_trunc = trunc_q;
endmodule

// File: tb/tb_packet_filler.sv
// Bench for packet_filler: a default-depth and a 4-word instance share one stimulus stream.
module tb_packet_filler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, s_tvalid, s_tlast, pkt_ack;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;

    logic        b_tready, b_wr_en, b_ready, b_trunc;
    logic [9:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [12:0] b_len;
    logic        m_tready, m_wr_en, m_ready, m_trunc;
    logic [1:0]  m_wr_addr;
    logic [31:0] m_wr_data;
    logic [4:0]  m_len;

    packet_filler #(.ADDR_WIDTH(10)) u_big (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(b_tready),
        .s_tlast(s_tlast), .s_tkeep(s_tkeep), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_en(b_wr_en), .pkt_ready(b_ready), .pkt_len(b_len), .pkt_trunc(b_trunc),
        .pkt_ack(pkt_ack));

    packet_filler #(.ADDR_WIDTH(2)) u_small (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(m_tready),
        .s_tlast(s_tlast), .s_tkeep(s_tkeep), .wr_addr(m_wr_addr), .wr_data(m_wr_data),
        .wr_en(m_wr_en), .pkt_ready(m_ready), .pkt_len(m_len), .pkt_trunc(m_trunc),
        .pkt_ack(pkt_ack));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: the packet is just a count of accepted beats plus "closed" (tlast seen)
    // and how many cycles it has been closed; outputs follow from those.
    int          dep [2] = '{1024, 4};
    int          n_beats = 0;
    bit          closed = 0;
    int          age = 0;
    logic [3:0]  last_keep = 4'hF;
    bit          e_wr [2];
    int          e_addr [2];
    logic [31:0] e_data [2];

    function automatic int exp_len(input int d);
        int b;
        b = 4 * ((n_beats < d) ? n_beats : d);
`ifdef PACKET_FILLER_TKEEP_EN
        if (closed && n_beats <= d) b = b - 4 + $countones(last_keep);
`endif
        return b;
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            n_beats = 0; closed = 0; age = 0;
            e_wr[0] = 0; e_wr[1] = 0;
        end else begin
            acc = s_tvalid && !closed;
            for (int i = 0; i < 2; i++) begin
                e_wr[i] = acc && (n_beats < dep[i]);
                if (e_wr[i]) begin
                    e_addr[i] = n_beats;
                    e_data[i] = s_tdata;
                end
            end
            if (acc) begin
                n_beats++;
                if (s_tlast) begin
                    closed = 1; age = 0; last_keep = s_tkeep;
                end
            end else if (closed) begin
                if (age >= 1 && pkt_ack) begin
                    n_beats = 0; closed = 0; age = 0;
                end else if (age < 1) begin
                    age++;
                end
            end
        end
    end

    bit cmp_en = 0;
    int wr_cnt [2] = '{0, 0};
    int wlog_addr [$];
    logic [31:0] wlog_data [$];

    task automatic cmp_inst(input int i, input logic tready, input logic wen, input int addr,
                            input logic [31:0] data, input logic rdy, input int len, input logic trunc);
        bit e_rdy;
        e_rdy = closed && age >= 1;
        chk($sformatf("tready[%0d]", i), tready, !closed && !rst);
        chk($sformatf("wr_en[%0d]", i), wen, e_wr[i]);
        if (e_wr[i]) begin
            chk($sformatf("wr_addr[%0d]", i), addr, e_addr[i]);
            chk($sformatf("wr_data[%0d]", i), data, e_data[i]);
        end
        chk($sformatf("pkt_ready[%0d]", i), rdy, e_rdy);
        chk($sformatf("pkt_trunc[%0d]", i), trunc, n_beats > dep[i]);
        if (e_rdy) chk($sformatf("pkt_len[%0d]", i), len, exp_len(dep[i]));
    endtask

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            cmp_inst(0, b_tready, b_wr_en, int'(b_wr_addr), b_wr_data, b_ready, int'(b_len), b_trunc);
            cmp_inst(1, m_tready, m_wr_en, int'(m_wr_addr), m_wr_data, m_ready, int'(m_len), m_trunc);
            if (b_wr_en === 1'b1) begin
                wr_cnt[0]++;
                wlog_addr.push_back(int'(b_wr_addr));
                wlog_data.push_back(b_wr_data);
            end
            if (m_wr_en === 1'b1) wr_cnt[1]++;
        end
    end

    task automatic beat(input logic [31:0] d, input bit last, input logic [3:0] k, input int gap);
        int w;
        repeat (gap) begin
            @(negedge clk);
            s_tvalid = 0; s_tlast = 0;
        end
        @(negedge clk);
        s_tvalid = 1; s_tdata = d; s_tlast = last; s_tkeep = k;
        #1;
        w = 0;
        while (!b_tready && w < 50) begin
            @(negedge clk); #1; w++;
        end
        if (w >= 50) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        s_tvalid = 0; s_tlast = 0;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!b_ready && w < 20) begin
            @(negedge clk); w++;
        end
        if (w >= 20) chk("ready_timeout", 0, 1);
    endtask

    task automatic ack();
        @(negedge clk);
        s_tvalid = 0; s_tlast = 0; pkt_ack = 1;
        @(negedge clk);
        pkt_ack = 0;
        chk("tready_after_ack", b_tready, 1);
    endtask

    task automatic clear_logs();
        wr_cnt[0] = 0; wr_cnt[1] = 0;
        wlog_addr.delete(); wlog_data.delete();
    endtask

    initial begin
        rst = 1; s_tvalid = 0; s_tlast = 0; s_tdata = '0; s_tkeep = 4'hF; pkt_ack = 0;
        @(negedge clk);
        cmp_en = 1;
        @(negedge clk);
        chk("rst_wr_en", b_wr_en, 0);
        chk("rst_wr_addr", b_wr_addr, 0);
        chk("rst_wr_data", b_wr_data, 0);
        chk("rst_pkt_len", b_len, 0);
        chk("rst_tready_in_rst", b_tready, 0);
        rst = 0;
        #1 chk("tready_after_rst", b_tready, 1);

        // Three-beat packet
        clear_logs();
        beat(32'h01234567, 0, 4'hF, 0);
        beat(32'h89ABCDEF, 0, 4'hF, 0);
        beat(32'h55555555, 1, 4'hF, 0);
        @(negedge clk);
        chk("t1_not_ready_in_flush", b_ready, 0);
        @(negedge clk);
        chk("t1_ready_two_after", b_ready, 1);
        chk("t1_len", b_len, 12);
        chk("t1_trunc", b_trunc, 0);
        chk("t1_nwrites", wlog_addr.size(), 3);
        if (wlog_addr.size() == 3) begin
            chk("t1_addr2", wlog_addr[2], 2);
            chk("t1_data0", wlog_data[0], 32'h01234567);
            chk("t1_data1", wlog_data[1], 32'h89ABCDEF);
        end

        // Held valid during DONE is not accepted
        clear_logs();
        @(negedge clk);
        s_tvalid = 1; s_tdata = 32'hDEADBEEF; s_tlast = 0;
        repeat (4) @(negedge clk);
        chk("t2_tready_done", b_tready, 0);
        chk("t2_no_writes", wr_cnt[0], 0);
        ack();
        clear_logs();
        beat(32'hA0A0A0A0, 1, 4'hF, 0);
        wait_ready();
        chk("t2_restart_addr", (wlog_addr.size() > 0) ? wlog_addr[0] : -1, 0);
        chk("t2_len", b_len, 4);
        ack();

        // Six beats into the 4-word instance
        clear_logs();
        for (int i = 0; i < 6; i++) beat(32'h1000 + i, i == 5, 4'hF, 0);
        idle();
        wait_ready();
        chk("t3_small_len", m_len, 16);
        chk("t3_small_trunc", m_trunc, 1);
        chk("t3_small_writes", wr_cnt[1], 4);
        chk("t3_big_len", b_len, 24);
        chk("t3_big_writes", wr_cnt[0], 6);
        ack();

        // Partial final beat
        beat(32'h11223344, 0, 4'hF, 0);
        beat(32'h55660000, 1, 4'b1100, 0);
        idle();
        wait_ready();
`ifdef PACKET_FILLER_TKEEP_EN
        chk("t4_len_tkeep", b_len, 6);
`else
        chk("t4_len", b_len, 8);
`endif
        ack();

        // Reset mid-packet
        beat(32'h0000AAAA, 0, 4'hF, 0);
        beat(32'h0000BBBB, 0, 4'hF, 0);
        @(negedge clk);
        s_tvalid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        chk("t5_wr_en_after_rst", b_wr_en, 0);
        chk("t5_ready_after_rst", b_ready, 0);
        clear_logs();
        beat(32'h0000CCCC, 0, 4'hF, 0);
        beat(32'h0000DDDD, 1, 4'hF, 0);
        idle();
        wait_ready();
        chk("t5_len", b_len, 8);
        chk("t5_first_addr", (wlog_addr.size() > 0) ? wlog_addr[0] : -1, 0);
        ack();

        // Gaps between beats
        clear_logs();
        beat(32'hC0000000, 0, 4'hF, 0);
        beat(32'hC0000001, 0, 4'hF, 1);
        beat(32'hC0000002, 0, 4'hF, 2);
        beat(32'hC0000003, 1, 4'hF, 3);
        idle();
        wait_ready();
        chk("t6_len", b_len, 16);
        chk("t6_writes", wr_cnt[0], 4);
        if (wlog_addr.size() == 4) chk("t6_last_addr", wlog_addr[3], 3);
        ack();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
